hdmi_to_blocks: RTL

Front-end stage of the JPEG pipeline: converts an HDMI-style raster stream (N pixels per clock, Y/Cr/Cb) into a stream of 8x8 blocks in block order for the DCT/quantisation path. It buffers one 8-line strip in a ping-pong pair of strip RAMs and re-reads it block by block. Its block output uses exactly the block-interface format that `blocks_to_hdmi` consumes.

---
 rtl/hdmi_to_blocks_if.sv | 35 +++
 rtl/hdmi_to_blocks.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_to_blocks_if.sv
// hdmi_to_blocks_if: raster input and 8x8 block output bundle.
// Lane 0 of each component bus is the leftmost pixel.
interface hdmi_to_blocks_if #(
  parameter int N = 2
);
  logic                  hdmi_v_sync;
  logic                  hdmi_h_sync;
  logic                  hdmi_data_valid;
  logic signed [8*N-1:0] hdmi_data_y;
  logic signed [8*N-1:0] hdmi_data_cr;
  logic signed [8*N-1:0] hdmi_data_cb;
  logic                  blk_valid;
  logic signed [8*N-1:0] blk_data_y;
  logic signed [8*N-1:0] blk_data_cr;
  logic signed [8*N-1:0] blk_data_cb;
  logic                  blk_sob;
  logic                  blk_eob;
  logic                  blk_sof;
  logic                  err_overflow;
  logic                  err_line;

  modport master (
    output hdmi_v_sync, hdmi_h_sync, hdmi_data_valid,
    output hdmi_data_y, hdmi_data_cr, hdmi_data_cb,
    input  blk_valid, blk_data_y, blk_data_cr, blk_data_cb,
    input  blk_sob, blk_eob, blk_sof, err_overflow, err_line
  );

  modport slave (
    input  hdmi_v_sync, hdmi_h_sync, hdmi_data_valid,
    input  hdmi_data_y, hdmi_data_cr, hdmi_data_cb,
    output blk_valid, blk_data_y, blk_data_cr, blk_data_cb,
    output blk_sob, blk_eob, blk_sof, err_overflow, err_line
  );
endinterface

// File: rtl/hdmi_to_blocks.sv
// hdmi_to_blocks: raster stream to 8x8 block stream.
// One 8-line strip per ping-pong buffer, re-read in block order.
module hdmi_to_blocks #(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input logic             clk,
  input logic             rst,
  hdmi_to_blocks_if.slave bus
);
  localparam int W  = X_RES / N;
  localparam int D  = 8 * W;
  localparam int B  = X_RES / 8;
  localparam int S  = Y_RES / 8;
  localparam int E  = 8 / N;
  localparam int DW = 24 * N;
  localparam int AW = $clog2(D);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int EW = (E > 1) ? $clog2(E) : 1;

  typedef enum logic {IDLE, READ} state_t;

  logic          vs_q, hs_q;
  logic          wr_act, c_act;
  logic [CW-1:0] col, c_col;
  logic [2:0]    row, c_row;
  logic [SW-1:0] strip, c_strip;
  logic          wr_sel;
  logic          sof_pend;
  logic [1:0]    sof_buf;
  logic          vs_rise, hs_rise, line_err;
  logic          wr_en, col_last, strip_done, ovf, set_full;
  logic [AW-1:0] wr_addr;

  state_t        st, st_d;
  logic [1:0]    full, full_d, set_vec, clr_vec;
  logic          rd_buf, rd_on, rd_last, elem_last, blk_last;
  logic [BW-1:0] blk;
  logic [2:0]    line;
  logic [EW-1:0] elem;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] mem [2*D];
  logic [DW-1:0] rd_q;
  logic          p1_v, p1_sob, p1_eob, p1_sof;

  // Sync edges are applied before the beat of the same cycle.
  always_comb begin
    vs_rise  = bus.hdmi_v_sync & ~vs_q;
    hs_rise  = bus.hdmi_h_sync & ~hs_q;
    c_act    = wr_act;
    c_col    = col;
    c_row    = row;
    c_strip  = strip;
    line_err = 1'b0;
    if (vs_rise) begin
      c_act   = 1'b1;
      c_col   = '0;
      c_row   = '0;
      c_strip = '0;
    end else if (hs_rise && col != '0) begin
      c_col    = '0;
      line_err = 1'b1;
    end
    wr_en      = c_act & bus.hdmi_data_valid;
    col_last   = (c_col == CW'(W - 1));
    strip_done = wr_en & col_last & (c_row == 3'd7);
    ovf        = strip_done & full[~wr_sel];
    set_full   = strip_done & ~ovf;
    wr_addr    = AW'(c_row) * AW'(W) + AW'(c_col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q             <= 1'b0;
      hs_q             <= 1'b0;
      wr_act           <= 1'b0;
      col              <= '0;
      row              <= '0;
      strip            <= '0;
      wr_sel           <= 1'b0;
      sof_pend         <= 1'b0;
      sof_buf          <= '0;
      bus.err_line     <= 1'b0;
      bus.err_overflow <= 1'b0;
    end else begin
      vs_q             <= bus.hdmi_v_sync;
      hs_q             <= bus.hdmi_h_sync;
      bus.err_line     <= line_err;
      bus.err_overflow <= ovf;
      wr_act           <= c_act;
      col              <= c_col;
      row              <= c_row;
      strip            <= c_strip;
      if (vs_rise)
        sof_pend <= 1'b1;
      if (wr_en) begin
        col <= col_last ? '0 : c_col + 1'b1;
        if (col_last)
          row <= c_row + 3'd1;
      end
      if (strip_done) begin
        strip <= (c_strip == SW'(S - 1)) ? '0 : c_strip + 1'b1;
        if (c_strip == SW'(S - 1))
          wr_act <= 1'b0;
        if (c_strip == '0)
          sof_pend <= 1'b0;
        if (set_full) begin
          wr_sel          <= ~wr_sel;
          sof_buf[wr_sel] <= sof_pend & (c_strip == '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{wr_sel, wr_addr}] <= {bus.hdmi_data_cb, bus.hdmi_data_cr,
                                 bus.hdmi_data_y};
    rd_q <= mem[{rd_buf, rd_addr}];
  end

  // Buffers fill strictly alternately, so rd_buf doubles as the order FIFO.
  always_comb begin
    rd_on     = (st == READ);
    elem_last = (elem == EW'(E - 1));
    blk_last  = (blk == BW'(B - 1));
    rd_last   = rd_on & blk_last & (line == 3'd7) & elem_last;
    rd_addr   = AW'(blk) * AW'(E) + AW'(line) * AW'(W) + AW'(elem);
    set_vec   = {set_full & wr_sel, set_full & ~wr_sel};
    clr_vec   = '0;
    st_d      = st;
    unique case (st)
      IDLE: if (full[rd_buf]) st_d = READ;
      READ: begin
        if (rd_last) begin
          clr_vec[rd_buf] = 1'b1;
          if (!(full[~rd_buf] | set_vec[~rd_buf]))
            st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
    full_d = (full | set_vec) & ~clr_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      full   <= '0;
      rd_buf <= 1'b0;
      blk    <= '0;
      line   <= '0;
      elem   <= '0;
    end else begin
      st   <= st_d;
      full <= full_d;
      if (rd_on) begin
        if (elem_last) begin
          elem <= '0;
          line <= line + 3'd1;
          if (line == 3'd7)
            blk <= blk_last ? '0 : blk + 1'b1;
        end else begin
          elem <= elem + 1'b1;
        end
      end
      if (rd_last)
        rd_buf <= ~rd_buf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_v            <= 1'b0;
      p1_sob          <= 1'b0;
      p1_eob          <= 1'b0;
      p1_sof          <= 1'b0;
      bus.blk_valid   <= 1'b0;
      bus.blk_sob     <= 1'b0;
      bus.blk_eob     <= 1'b0;
      bus.blk_sof     <= 1'b0;
      bus.blk_data_y  <= '0;
      bus.blk_data_cr <= '0;
      bus.blk_data_cb <= '0;
    end else begin
      p1_v   <= rd_on;
      p1_sob <= rd_on & (line == 3'd0) & (elem == '0);
      p1_eob <= rd_on & (line == 3'd7) & elem_last;
      p1_sof <= rd_on & (line == 3'd0) & (elem == '0) & (blk == '0)
                & sof_buf[rd_buf];
      bus.blk_valid <= p1_v;
      bus.blk_sob   <= p1_sob;
      bus.blk_eob   <= p1_eob;
      bus.blk_sof   <= p1_sof;
      if (p1_v) begin
        bus.blk_data_y  <= rd_q[8*N-1:0];
        bus.blk_data_cr <= rd_q[16*N-1:8*N];
        bus.blk_data_cb <= rd_q[24*N-1:16*N];
      end
    end
  end
endmodule
